result_unloader: RTL and testbench



---
 rtl/result_unloader_if.sv | 30 +++
 rtl/result_unloader.sv | 131 +++++++++++++
 tb/tb_result_unloader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_unloader_if.sv
// Memory read port and result stream of the result unloader.
// Stream handshake: a beat transfers on a rising clk edge where out_valid and out_ready are both high; once raised, out_valid and the payload (out_data, out_index, out_last) hold until that edge.
`timescale 1ns/1ps
interface result_unloader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_address, mem_read_enable,
    input  mem_data_out,
    output out_data, out_index, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_read_enable,
    output mem_data_out,
    input  out_data, out_index, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_unloader.sv
// Drains the five per-set partial results and the grand total from the shared memory,
// streams them out and flags whether the partials sum to the stored total.
`timescale 1ns/1ps
module result_unloader #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 5,
  parameter int NUM_SETS      = 5,
  parameter int SET_STRIDE    = 5,
  parameter int RESULT_OFFSET = 4,
  parameter int TOTAL_ADDR    = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  result_unloader_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               check_ok,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_SETS);

  state_t            state, state_nx;
  logic [2:0]        idx;
  logic [DATA_W-1:0] sum;
  logic              start_d;
  logic              trigger;
  logic [ADDR_W-1:0] partial_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] out_data_q;
  logic [2:0]        out_index_q;
  logic              out_valid_q;
  logic              out_last_q;

  // Only a rising edge of start counts, so the controller's two-cycle ready yields one drain.
  assign trigger      = start && !start_d && (state == S_IDLE);
  assign partial_addr = ADDR_W'(RESULT_OFFSET) + ADDR_W'(idx) * ADDR_W'(SET_STRIDE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (trigger) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en    = 1'b1;
        rd_addr  = (idx < LAST_IDX) ? partial_addr : ADDR_W'(TOTAL_ADDR);
        state_nx = S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_PRESENT;
      S_PRESENT: begin
        if (bus.out_ready) state_nx = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // start_d resets high so a start level held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx         <= '0;
      sum         <= '0;
      start_d     <= 1'b1;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      check_ok    <= 1'b0;
    end else begin
      start_d <= start;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            idx      <= '0;
            sum      <= '0;
            check_ok <= 1'b0;
          end
        end
        S_CAPTURE: begin
          out_data_q  <= bus.mem_data_out;
          out_index_q <= idx;
          out_last_q  <= (idx == LAST_IDX);
          out_valid_q <= 1'b1;
          if (idx < LAST_IDX) sum      <= sum + bus.mem_data_out;
          else                check_ok <= (sum == bus.mem_data_out);
        end
        S_PRESENT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_address     = rd_addr;
  assign bus.mem_read_enable = rd_en;
  assign bus.out_data        = out_data_q;
  assign bus.out_index       = out_index_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_last        = out_last_q;
  assign dbg_state           = state;

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: a registered memory model, directed drains,
// and a negedge monitor that checks stream beats and read addresses against expected queues.
`timescale 1ns/1ps
module tb_result_unloader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, check_ok;
  logic [2:0] dbg_state;

  result_unloader_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  result_unloader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .check_ok  (check_ok),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !reset_n;
  end

  // ---------------- memory model: data valid the cycle after the strobe ----------------
  logic [15:0] mem [32];
  logic [15:0] mem_q = 16'h0;
  int          rd_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_read_enable) begin
      mem_q  <= mem[bus.mem_address];
      rd_cnt <= rd_cnt + 1;
    end
  end
  assign bus.mem_data_out = mem_q;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];
  logic [4:0]  exp_addr_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic        hold_prev = 1'b0;
  logic [19:0] hold_val = '0;
  always @(negedge clk) begin
    logic [19:0] cur;
    cur = {bus.out_index, bus.out_last, bus.out_data};
    if (hold_prev && !rst_at_edge) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_payload", 32'(cur), 32'(hold_val));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
      else                   chk("beat", 32'(cur), 32'(exp_q.pop_front()));
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    hold_val  = cur;
    if (bus.mem_read_enable) begin
      if (exp_addr_q.size() == 0) chk("unexpected_read", 32'(exp_addr_q.size()), 32'd1);
      else                        chk("read_addr", 32'(bus.mem_address), 32'(exp_addr_q.pop_front()));
    end else begin
      chk("idle_addr", 32'(bus.mem_address), 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [15:0] p0, p1, p2, p3, p4, tot);
    for (int a = 0; a < 32; a++) mem[a] = 16'hA500 + 16'(a);
    mem[4] = p0; mem[9] = p1; mem[14] = p2; mem[19] = p3; mem[24] = p4; mem[31] = tot;
    exp_q.push_back({3'd0, 1'b0, p0});
    exp_q.push_back({3'd1, 1'b0, p1});
    exp_q.push_back({3'd2, 1'b0, p2});
    exp_q.push_back({3'd3, 1'b0, p3});
    exp_q.push_back({3'd4, 1'b0, p4});
    exp_q.push_back({3'd5, 1'b1, tot});
    exp_addr_q.push_back(5'd4);
    exp_addr_q.push_back(5'd9);
    exp_addr_q.push_back(5'd14);
    exp_addr_q.push_back(5'd19);
    exp_addr_q.push_back(5'd24);
    exp_addr_q.push_back(5'd31);
  endtask

  // Controller-style ready: high for two cycles.
  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_issue(input string name, input logic [4:0] addr);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.mem_read_enable && bus.mem_address == addr) && k < 60);
    chk(name, 32'(bus.mem_read_enable && bus.mem_address == addr), 32'd1);
  endtask

  task automatic finish_drain(input string name, input logic exp_ok, input int db, input int rb,
                              input logic timed);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 200);
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    tick(); tick(); tick();
    chk({name, "_done_count"}, 32'(done_cnt - db), 32'd1);
    chk({name, "_reads"}, 32'(rd_cnt - rb), 32'd6);
    chk({name, "_check_ok"}, 32'(check_ok), 32'(exp_ok));
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    if (timed) chk({name, "_done_cycle"}, 32'(done_cyc), 32'(start_cyc + 19));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int db, rb;
    bus.out_ready = 1'b1;
    for (int a = 0; a < 32; a++) mem[a] = 16'h0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_check_ok", 32'(check_ok), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_read_enable), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    reset_n = 1'b1;
    tick(); tick();

    // nominal
    setup(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    finish_drain("nominal", 1'b1, db, rb, 1'b1);

    // backpressure on index 2 for four cycles
    setup(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    wait_issue("bp_issue2", 5'd14);
    tick();
    bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'd30);
      chk("bp_index", 32'(bus.out_index), 32'd2);
      chk("bp_no_read", 32'(bus.mem_read_enable), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    finish_drain("backpressure", 1'b1, db, rb, 1'b0);

    // total mismatch
    setup(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd151);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    finish_drain("mismatch", 1'b0, db, rb, 1'b1);

    // 16-bit wrap: 5 * 0xFFFF = 0x4FFFB
    setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFB);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    finish_drain("wrap", 1'b1, db, rb, 1'b1);

    // reset while index 3 is presented, with start held high across release
    setup(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    wait_issue("rst_issue3", 5'd19);
    tick();
    bus.out_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_pre_index", 32'(bus.out_index), 32'd3);
    chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    tick();
    start   = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_check_ok", 32'(check_ok), 32'd0);
    chk("abort_rd_en", 32'(bus.mem_read_enable), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    tick();
    bus.out_ready = 1'b1;
    db = done_cnt; rb = rd_cnt;
    repeat (8) begin
      tick();
      chk("held_start_busy", 32'(busy), 32'd0);
    end
    chk("held_start_reads", 32'(rd_cnt - rb), 32'd0);
    chk("abort_no_done", 32'(done_cnt - db), 32'd0);
    start = 1'b0;
    tick(); tick();
    setup(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    finish_drain("restart", 1'b1, db, rb, 1'b1);

    // start edge while busy is ignored
    setup(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd45);
    db = done_cnt; rb = rd_cnt;
    pulse_start();
    repeat (4) tick();
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    finish_drain("ignored_start", 1'b1, db, rb, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
